// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data port arbiter onto one memory channel; define ARB_STARVE_GUARD_EN to enable the fetch starvation guard
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic        m_write_enable,
    output logic        m_valid,
    input  logic        m_data_ready,
    input  logic [31:0] m_data_out,
    output logic [1:0]  grant
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
    state_t state;
    logic   pick_i;
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end
`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    // Fetch wins when alone, or when data has taken the bus STARVE_LIMIT times in a row while fetch waited
    always_comb pick_i = i_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT));
    // Count consecutive data grants that left the fetch port waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (state == IDLE && (i_req || d_req))
            starve_cnt <= (pick_i || !i_req) ? 4'd0 : starve_cnt + 4'd1;
    end
`else
    // Strict data-port priority
    always_comb pick_i = i_req && !d_req;
`endif
    // Arbitrate in IDLE, hold the registered bus request until memory completes, then pulse the owner's ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            grant          <= 2'b00;
            m_valid        <= 1'b0;
            m_write_enable <= 1'b0;
            m_address      <= '0;
            m_data_in      <= '0;
            i_ready        <= 1'b0;
            d_ready        <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    state          <= pick_i ? GNT_I : GNT_D;
                    grant          <= pick_i ? 2'b01 : 2'b10;
                    m_valid        <= 1'b1;
                    m_address      <= pick_i ? i_addr : d_addr;
                    m_data_in      <= pick_i ? 32'd0 : d_wdata;
                    m_write_enable <= !pick_i && d_we;
                end
                GNT_I, GNT_D: if (m_data_ready) begin
                    state          <= RESP;
                    grant          <= 2'b00;
                    m_valid        <= 1'b0;
                    m_write_enable <= 1'b0;
                    i_ready        <= state == GNT_I;
                    d_ready        <= state == GNT_D;
                    if (state == GNT_I)
                        i_rdata <= m_data_out;
                    else if (!m_write_enable)
                        d_rdata <= m_data_out;
                end
                default: begin
                    state   <= IDLE;
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
